// File: rtl/noc_dor_route_unit.sv
// Dimension-ordered route unit for one mesh-router input port.
// Decodes the header route, holds it for the packet body, and presents flits through a one-deep output register.
module noc_dor_route_unit #(
    parameter int unsigned dims_p         = 2,
    parameter int unsigned x_cord_width_p = 10,
    parameter int unsigned y_cord_width_p = 20,
    parameter int unsigned trans_p        = 0,
    parameter int unsigned len_width_p    = 4,
    parameter int unsigned flit_width_p   = 64,
    localparam int unsigned cord_width_lp = (dims_p == 2) ? (x_cord_width_p + y_cord_width_p)
                                                          : x_cord_width_p,
    localparam int unsigned dirs_lp       = 1 + 2 * dims_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [cord_width_lp-1:0] my_cord_i,
    input  logic                     v_i,
    input  logic [flit_width_p-1:0]  flit_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [flit_width_p-1:0]  flit_o,
    output logic [dirs_lp-1:0]       dir_o,
    output logic                     head_o,
    output logic                     tail_o,
    input  logic                     ready_i
);

    localparam logic [0:0] S_HEAD = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    if (dims_p != 1 && dims_p != 2) begin : g_chk_dims
        $fatal(1, "noc_dor_route_unit: dims_p must be 1 or 2");
    end
    if (x_cord_width_p == 0 || (dims_p == 2 && y_cord_width_p == 0)) begin : g_chk_cord
        $fatal(1, "noc_dor_route_unit: coordinate widths must be non-zero");
    end
    if (flit_width_p < cord_width_lp + len_width_p) begin : g_chk_flit
        $fatal(1, "noc_dor_route_unit: flit_width_p too small for header fields");
    end

    logic [0:0]              state_q, state_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [dirs_lp-1:0]      route_q, route_d;
    logic                    v_q, v_d;
    logic [flit_width_p-1:0] flit_q, flit_d;
    logic [dirs_lp-1:0]      dir_q, dir_d;
    logic                    head_q, head_d;
    logic                    tail_q, tail_d;

    logic [dirs_lp-1:0]      route_c;
    logic [len_width_p-1:0]  len_c;
    logic                    accept_c;

    assign len_c = flit_i[cord_width_lp+len_width_p-1:cord_width_lp];

    // Route decode: the low header field is the first-routed dimension.
    if (dims_p == 2) begin : g_dec_2d
        localparam int unsigned f_w_lp  = (trans_p != 0) ? y_cord_width_p : x_cord_width_p;
        localparam int unsigned s_w_lp  = cord_width_lp - f_w_lp;
        localparam int unsigned f_lo_lp = (trans_p != 0) ? 3 : 1;
        localparam int unsigned f_hi_lp = (trans_p != 0) ? 4 : 2;
        localparam int unsigned s_lo_lp = (trans_p != 0) ? 1 : 3;
        localparam int unsigned s_hi_lp = (trans_p != 0) ? 2 : 4;

        logic [f_w_lp-1:0] dst_f, my_f;
        logic [s_w_lp-1:0] dst_s, my_s;

        assign dst_f = flit_i[f_w_lp-1:0];
        assign my_f  = my_cord_i[f_w_lp-1:0];
        assign dst_s = flit_i[cord_width_lp-1:f_w_lp];
        assign my_s  = my_cord_i[cord_width_lp-1:f_w_lp];

        always_comb begin
            route_c = '0;
            if (dst_f < my_f)      route_c[f_lo_lp] = 1'b1;
            else if (dst_f > my_f) route_c[f_hi_lp] = 1'b1;
            else if (dst_s < my_s) route_c[s_lo_lp] = 1'b1;
            else if (dst_s > my_s) route_c[s_hi_lp] = 1'b1;
            else                   route_c[0]       = 1'b1;
        end
    end else begin : g_dec_1d
        logic [cord_width_lp-1:0] dst_x;

        assign dst_x = flit_i[cord_width_lp-1:0];

        always_comb begin
            route_c = '0;
            if (dst_x < my_cord_i)      route_c[1] = 1'b1;
            else if (dst_x > my_cord_i) route_c[2] = 1'b1;
            else                        route_c[0] = 1'b1;
        end
    end

    // Output register accepts whenever it is empty or draining this cycle.
    assign ready_o  = ~v_q | ready_i;
    assign accept_c = v_i & ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        route_d = route_q;
        v_d     = v_q;
        flit_d  = flit_q;
        dir_d   = dir_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (accept_c) begin
            v_d    = 1'b1;
            flit_d = flit_i;
            case (state_q)
                S_HEAD: begin
                    route_d = route_c;
                    cnt_d   = len_c;
                    dir_d   = route_c;
                    head_d  = 1'b1;
                    tail_d  = (len_c == '0);
                    if (len_c != '0) state_d = S_BODY;
                end
                S_BODY: begin
                    cnt_d  = cnt_q - len_width_p'(1);
                    dir_d  = route_q;
                    head_d = 1'b0;
                    tail_d = (cnt_q == len_width_p'(1));
                    if (cnt_q == len_width_p'(1)) state_d = S_HEAD;
                end
                default: state_d = S_HEAD;
            endcase
        end else if (ready_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_HEAD;
            cnt_q   <= '0;
            route_q <= '0;
            v_q     <= 1'b0;
            flit_q  <= '0;
            dir_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            route_q <= route_d;
            v_q     <= v_d;
            flit_q  <= flit_d;
            dir_q   <= dir_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign v_o    = v_q;
    assign flit_o = flit_q;
    assign dir_o  = dir_q;
    assign head_o = head_q;
    assign tail_o = tail_q;

endmodule

// File: tb/tb_noc_dor_route_unit.sv
// Directed bench for noc_dor_route_unit: XY, YX and 1-D instances checked against hand-computed routes.
module tb_noc_dor_route_unit;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance a: defaults (XY, X low 10 bits, Y upper 20 bits)
    logic [29:0] a_my;
    logic        a_v_i, a_ready_o, a_v_o, a_head_o, a_tail_o, a_ready_i;
    logic [63:0] a_flit_i, a_flit_o;
    logic [4:0]  a_dir_o;

    // Instance b: YX (Y low 20 bits, X upper 10 bits)
    logic [29:0] b_my;
    logic        b_v_i, b_ready_o, b_v_o, b_head_o, b_tail_o, b_ready_i;
    logic [63:0] b_flit_i, b_flit_o;
    logic [4:0]  b_dir_o;

    // Instance c: 1-D, 4-bit X, 12-bit flits
    logic [3:0]  c_my;
    logic        c_v_i, c_ready_o, c_v_o, c_head_o, c_tail_o, c_ready_i;
    logic [11:0] c_flit_i, c_flit_o;
    logic [2:0]  c_dir_o;

    noc_dor_route_unit u_dut_a (
        .clk_i(clk), .reset_i(reset_i), .my_cord_i(a_my), .v_i(a_v_i), .flit_i(a_flit_i),
        .ready_o(a_ready_o), .v_o(a_v_o), .flit_o(a_flit_o), .dir_o(a_dir_o),
        .head_o(a_head_o), .tail_o(a_tail_o), .ready_i(a_ready_i)
    );

    noc_dor_route_unit #(.trans_p(1)) u_dut_b (
        .clk_i(clk), .reset_i(reset_i), .my_cord_i(b_my), .v_i(b_v_i), .flit_i(b_flit_i),
        .ready_o(b_ready_o), .v_o(b_v_o), .flit_o(b_flit_o), .dir_o(b_dir_o),
        .head_o(b_head_o), .tail_o(b_tail_o), .ready_i(b_ready_i)
    );

    noc_dor_route_unit #(.dims_p(1), .x_cord_width_p(4), .len_width_p(4), .flit_width_p(12)) u_dut_c (
        .clk_i(clk), .reset_i(reset_i), .my_cord_i(c_my), .v_i(c_v_i), .flit_i(c_flit_i),
        .ready_o(c_ready_o), .v_o(c_v_o), .flit_o(c_flit_o), .dir_o(c_dir_o),
        .head_o(c_head_o), .tail_o(c_tail_o), .ready_i(c_ready_i)
    );

    function automatic logic [63:0] hdr_a(input logic [9:0] x, input logic [19:0] y,
                                          input logic [3:0] len, input logic [29:0] tag);
        return {tag, len, y, x};
    endfunction

    function automatic logic [63:0] hdr_b(input logic [9:0] x, input logic [19:0] y,
                                          input logic [3:0] len, input logic [29:0] tag);
        return {tag, len, x, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        n_checks++; if (a_v_o !== 1'b0)    begin n_fail++; $display("FAIL reset_v_o: got %b exp 0", a_v_o); end
        n_checks++; if (a_flit_o !== '0)   begin n_fail++; $display("FAIL reset_flit_o: got %h exp 0", a_flit_o); end
        n_checks++; if (a_dir_o !== 5'b0)  begin n_fail++; $display("FAIL reset_dir_o: got %b exp 00000", a_dir_o); end
        n_checks++; if (a_head_o !== 1'b0 || a_tail_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_head_tail: got %b%b exp 00", a_head_o, a_tail_o); end
        n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o: got %b exp 1", a_ready_o); end
        n_checks++; if (b_v_o !== 1'b0 || c_v_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_v_o_bc: got %b%b exp 00", b_v_o, c_v_o); end
        reset_i = 1'b0;
    endtask

    task automatic test_xy_decode();
        logic [63:0] fl[4];
        logic [4:0]  ed[4];
        fl[0] = hdr_a(10'd9, 20'd2, 4'd0, 30'h11); ed[0] = 5'b00100;
        fl[1] = hdr_a(10'd5, 20'd2, 4'd0, 30'h12); ed[1] = 5'b01000;
        fl[2] = hdr_a(10'd5, 20'd9, 4'd0, 30'h13); ed[2] = 5'b10000;
        fl[3] = hdr_a(10'd5, 20'd7, 4'd0, 30'h14); ed[3] = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            a_v_i = 1'b1; a_flit_i = fl[k];
            step();
            n_checks++; if (a_v_o !== 1'b1 || a_dir_o !== ed[k] || a_head_o !== 1'b1 || a_tail_o !== 1'b1)
                begin n_fail++; $display("FAIL xy_decode[%0d]: got v%b dir %b h%b t%b exp v1 dir %b h1 t1",
                                         k, a_v_o, a_dir_o, a_head_o, a_tail_o, ed[k]); end
            n_checks++; if (a_flit_o !== fl[k])
                begin n_fail++; $display("FAIL xy_flit[%0d]: got %h exp %h", k, a_flit_o, fl[k]); end
        end
        a_v_i = 1'b0;
        step();
        n_checks++; if (a_v_o !== 1'b0) begin n_fail++; $display("FAIL xy_drain: got v_o %b exp 0", a_v_o); end
    endtask

    task automatic test_yx_decode();
        logic [63:0] fl[4];
        logic [4:0]  ed[4];
        fl[0] = hdr_b(10'd9, 20'd2, 4'd0, 30'h21); ed[0] = 5'b01000;
        fl[1] = hdr_b(10'd9, 20'd7, 4'd0, 30'h22); ed[1] = 5'b00100;
        fl[2] = hdr_b(10'd5, 20'd7, 4'd0, 30'h23); ed[2] = 5'b00001;
        fl[3] = hdr_b(10'd1, 20'd9, 4'd0, 30'h24); ed[3] = 5'b10000;
        for (int k = 0; k < 4; k++) begin
            b_v_i = 1'b1; b_flit_i = fl[k];
            step();
            n_checks++; if (b_v_o !== 1'b1 || b_dir_o !== ed[k] || b_head_o !== 1'b1 || b_tail_o !== 1'b1)
                begin n_fail++; $display("FAIL yx_decode[%0d]: got v%b dir %b h%b t%b exp v1 dir %b h1 t1",
                                         k, b_v_o, b_dir_o, b_head_o, b_tail_o, ed[k]); end
        end
        b_v_i = 1'b0;
        step();
    endtask

    task automatic test_wormhole();
        logic [63:0] fl[5];
        logic [4:0]  ed[5];
        logic        eh[5], et[5];
        fl[0] = hdr_a(10'd2, 20'd7, 4'd3, 30'h31);          ed[0] = 5'b00010; eh[0] = 1; et[0] = 0;
        for (int k = 1; k < 4; k++) begin
            fl[k] = hdr_a(10'd9, 20'd2, 4'd0, 30'h300 + 30'(k)); ed[k] = 5'b00010; eh[k] = 0; et[k] = (k == 3);
        end
        fl[4] = hdr_a(10'd5, 20'd7, 4'd0, 30'h35);          ed[4] = 5'b00001; eh[4] = 1; et[4] = 1;
        for (int k = 0; k < 5; k++) begin
            a_v_i = 1'b1; a_flit_i = fl[k];
            step();
            n_checks++; if (a_v_o !== 1'b1 || a_dir_o !== ed[k] || a_head_o !== eh[k] || a_tail_o !== et[k])
                begin n_fail++; $display("FAIL wormhole[%0d]: got v%b dir %b h%b t%b exp v1 dir %b h%b t%b",
                                         k, a_v_o, a_dir_o, a_head_o, a_tail_o, ed[k], eh[k], et[k]); end
            n_checks++; if (a_flit_o !== fl[k])
                begin n_fail++; $display("FAIL wormhole_flit[%0d]: got %h exp %h", k, a_flit_o, fl[k]); end
        end
        a_v_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] sent[8];
        logic [63:0] rx[$];
        logic [63:0] mf;
        logic        mv, exp_rdy, acc;
        int          idx, cyc;
        sent[0] = hdr_a(10'd9, 20'd2, 4'd7, 30'h0B0);
        for (int k = 1; k < 8; k++) sent[k] = {30'h0B00 + 30'(k), 4'hA, 20'd1, 10'd1};
        mv = 1'b0; mf = '0; idx = 0; cyc = 0;
        while (cyc < 40 && !(idx == 8 && !mv)) begin
            a_ready_i = !(cyc >= 2 && cyc < 6);
            a_v_i     = (idx < 8);
            a_flit_i  = sent[(idx < 8) ? idx : 0];
            #2;
            exp_rdy = !mv || a_ready_i;
            n_checks++; if (a_ready_o !== exp_rdy)
                begin n_fail++; $display("FAIL bp_ready_o cyc %0d: got %b exp %b", cyc, a_ready_o, exp_rdy); end
            if (a_v_o && a_ready_i) rx.push_back(a_flit_o);
            acc = a_v_i && exp_rdy;
            step();
            if (acc) begin mv = 1'b1; mf = sent[idx]; idx++; end
            else if (a_ready_i) mv = 1'b0;
            n_checks++; if (a_v_o !== mv)
                begin n_fail++; $display("FAIL bp_v_o cyc %0d: got %b exp %b", cyc, a_v_o, mv); end
            if (mv) begin
                n_checks++; if (a_flit_o !== mf || a_dir_o !== 5'b00100)
                    begin n_fail++; $display("FAIL bp_hold cyc %0d: got %h/%b exp %h/00100", cyc, a_flit_o, a_dir_o, mf); end
            end
            cyc++;
        end
        a_v_i = 1'b0; a_ready_i = 1'b1;
        n_checks++; if (idx != 8 || mv)
            begin n_fail++; $display("FAIL bp_timeout: sent %0d exp 8", idx); end
        n_checks++; if (rx.size() != 8)
            begin n_fail++; $display("FAIL bp_count: got %0d exp 8", rx.size()); end
        for (int k = 0; k < 8 && k < rx.size(); k++) begin
            n_checks++; if (rx[k] !== sent[k])
                begin n_fail++; $display("FAIL bp_order[%0d]: got %h exp %h", k, rx[k], sent[k]); end
        end
        step();
    endtask

    task automatic test_reset_mid_packet();
        logic [63:0] nh;
        a_v_i = 1'b1; a_flit_i = hdr_a(10'd9, 20'd2, 4'd5, 30'h41);
        step();
        for (int k = 0; k < 2; k++) begin
            a_flit_i = {30'h4100 + 30'(k), 4'd0, 20'd7, 10'd2};
            step();
        end
        n_checks++; if (a_dir_o !== 5'b00100 || a_head_o !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_body: got dir %b h%b exp 00100 h0", a_dir_o, a_head_o); end
        a_v_i = 1'b0; reset_i = 1'b1;
        step();
        n_checks++; if (a_v_o !== 1'b0 || a_dir_o !== 5'b0)
            begin n_fail++; $display("FAIL rstmid_clear: got v%b dir %b exp v0 dir 00000", a_v_o, a_dir_o); end
        reset_i = 1'b0;
        nh = hdr_a(10'd2, 20'd7, 4'd0, 30'h42);
        a_v_i = 1'b1; a_flit_i = nh;
        step();
        n_checks++; if (a_v_o !== 1'b1 || a_dir_o !== 5'b00010 || a_head_o !== 1'b1 || a_tail_o !== 1'b1)
            begin n_fail++; $display("FAIL rstmid_header: got v%b dir %b h%b t%b exp v1 dir 00010 h1 t1",
                                     a_v_o, a_dir_o, a_head_o, a_tail_o); end
        a_v_i = 1'b0;
        step();
    endtask

    task automatic test_1d_max_len();
        logic [11:0] fl;
        logic [2:0]  ed[3];
        logic [3:0]  em[3];
        logic [3:0]  ex[3];
        for (int k = 0; k < 16; k++) begin
            fl = (k == 0) ? {4'h5, 4'hF, 4'hF} : {4'(k), 4'h0, 4'h0};
            c_v_i = 1'b1; c_flit_i = fl;
            step();
            n_checks++; if (c_v_o !== 1'b1 || c_dir_o !== 3'b100 || c_head_o !== (k == 0) || c_tail_o !== (k == 15))
                begin n_fail++; $display("FAIL 1d_len15[%0d]: got v%b dir %b h%b t%b exp v1 dir 100 h%b t%b",
                                         k, c_v_o, c_dir_o, c_head_o, c_tail_o, (k == 0), (k == 15)); end
            n_checks++; if (c_flit_o !== fl)
                begin n_fail++; $display("FAIL 1d_flit[%0d]: got %h exp %h", k, c_flit_o, fl); end
        end
        em[0] = 4'h0; ex[0] = 4'h0; ed[0] = 3'b001;
        em[1] = 4'hF; ex[1] = 4'h0; ed[1] = 3'b010;
        em[2] = 4'hF; ex[2] = 4'hF; ed[2] = 3'b001;
        for (int k = 0; k < 3; k++) begin
            c_my = em[k];
            c_flit_i = {4'h6, 4'h0, ex[k]};
            step();
            n_checks++; if (c_dir_o !== ed[k] || c_head_o !== 1'b1 || c_tail_o !== 1'b1)
                begin n_fail++; $display("FAIL 1d_extreme[%0d]: got dir %b h%b t%b exp dir %b h1 t1",
                                         k, c_dir_o, c_head_o, c_tail_o, ed[k]); end
        end
        c_v_i = 1'b0;
        step();
    endtask

    initial begin
        reset_i = 1'b1;
        a_my = {20'd7, 10'd5}; b_my = {10'd5, 20'd7}; c_my = 4'h0;
        a_v_i = 1'b0; b_v_i = 1'b0; c_v_i = 1'b0;
        a_flit_i = '0; b_flit_i = '0; c_flit_i = '0;
        a_ready_i = 1'b1; b_ready_i = 1'b1; c_ready_i = 1'b1;
        test_reset();
        test_xy_decode();
        test_yx_decode();
        test_wormhole();
        test_back_to_back();
        test_reset_mid_packet();
        test_1d_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
